// File: rtl/serial_paralelo_sync_pkg.sv
// Shared serial-link definitions: FSM encoding and
// default comma/idle code words for the RX and TX sides.
package serial_paralelo_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } link_state_e;

  localparam logic [7:0] COMMA_DEF = 8'hBC;
  localparam logic [7:0] IDLE_DEF  = 8'h7C;
  localparam int         LOCK_DEF  = 4;

endpackage

// File: rtl/serial_paralelo_sync_if.sv
// Serial-in / parallel-out bundle between the line
// receiver and the parallel datapath.
interface serial_paralelo_sync_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             resync;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active_out;
  logic             idle_out;

  modport master (
    output data_in,
    output resync,
    input  data_out,
    input  valid_out,
    input  active_out,
    input  idle_out
  );

  modport slave (
    input  data_in,
    input  resync,
    output data_out,
    output valid_out,
    output active_out,
    output idle_out
  );
endinterface

// File: rtl/serial_comma_detect.sv
// Sliding WIDTH-bit window over the serial line with
// combinational comma / idle compare.
module serial_comma_detect #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COMMA     = '0,
  parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  output logic [WIDTH-1:0] w_o,
  output logic             is_comma_o,
  output logic             is_idle_o
);

  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-2:0] sr_d;

  assign w_o        = {sr_q, bit_i};
  assign sr_d       = w_o[WIDTH-2:0];
  assign is_comma_o = (w_o == COMMA);
  assign is_idle_o  = (w_o == IDLE_WORD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel receiver: comma search, lock
// qualification over LOCK_COMMAS words, then word output.
module serial_paralelo_sync
  import serial_paralelo_sync_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(COMMA_DEF),
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(IDLE_DEF),
  parameter int               LOCK_COMMAS = LOCK_DEF
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_sync_if.slave bus
);

  localparam int BCW = $clog2(WIDTH);
  localparam int CW  = $clog2(LOCK_COMMAS + 1);

  localparam logic [BCW-1:0] BC_LAST  = BCW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_LOCK = CW'(LOCK_COMMAS);

  logic [WIDTH-1:0] w;
  logic             is_comma;
  logic             is_idle;

  link_state_e      state_q, state_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
  logic             idle_q, idle_d;
  logic             boundary;

  serial_comma_detect #(
    .WIDTH     (WIDTH),
    .COMMA     (COMMA),
    .IDLE_WORD (IDLE_WORD)
  ) u_detect (
    .clk_i      (clk_32f),
    .rst_ni     (reset),
    .bit_i      (bus.data_in),
    .w_o        (w),
    .is_comma_o (is_comma),
    .is_idle_o  (is_idle)
  );

  assign boundary = (bc_q == BC_LAST);
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    idle_d  = idle_q;

    if (state_q != SEARCH) begin
      bc_d = boundary ? '0 : bc_q + BCW'(1);
    end

    if (bus.resync) begin
      state_d = SEARCH;
      bc_d    = '0;
      cnt_d   = '0;
      idle_d  = 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (is_comma) begin
            bc_d    = '0;
            cnt_d   = CW'(1);
            state_d = (LOCK_COMMAS > 1) ? ALIGN : ACTIVE;
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_LOCK) begin
                state_d = ACTIVE;
              end
            end else begin
              state_d = SEARCH;
              cnt_d   = '0;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            // commas keep alignment but carry no payload
            unique case (1'b1)
              is_comma: ;
              is_idle:  idle_d = 1'b1;
              default: begin
                data_d  = w;
                valid_d = 1'b1;
                idle_d  = 1'b0;
              end
            endcase
          end
        end
        default: begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      endcase
    end

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      bc_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.active_out = active_q;
  assign bus.idle_out   = idle_q;

endmodule
